stall_ctl: RTL

- Consumer side of the hazard unit's stall_87 output. Owns the PC register and the IF/ID pipeline register.
- Freezes fetch and decode while a stall is asserted, and injects a bubble into ID/EX.
- Applies ID-stage branch redirects and flushes the instruction fetched behind a taken branch.
- Adds a consecutive-stall watchdog that flags a stuck pipeline.

---
 rtl/stall_ctl_pkg.sv | 16 +
 rtl/stall_ctl_watchdog.sv | 57 +++++
 rtl/stall_ctl.sv | 115 +++++++++++
 3 files changed

// File: rtl/stall_ctl_pkg.sv
// Shared defaults and helpers for the fetch/decode stall controller.
// Holds the MIPS-style pipeline constants that stall_ctl parameters default to.
package stall_ctl_pkg;

    localparam int          PC_WIDTH_DEF  = 32;
    localparam int          INSTR_WIDTH   = 32;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam int          MAX_STALL_DEF = 4;

    // Even parity over an instruction word, for downstream integrity checkers
    function automatic logic instr_parity(input logic [INSTR_WIDTH-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/stall_ctl_watchdog.sv
// Consecutive-stall watchdog: saturating run counter plus a sticky error flag.
// A run of exactly MAX_STALL stalls is legal; one more latches the error.
module stall_watchdog
    import stall_ctl_pkg::*;
#(
    parameter int MAX_STALL = MAX_STALL_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    output logic stall_err
);

    localparam int                 RUN_W   = $clog2(MAX_STALL + 2);
    localparam logic [RUN_W-1:0]   RUN_MAX = RUN_W'(MAX_STALL + 1);
    localparam logic [RUN_W-1:0]   RUN_LIM = RUN_W'(MAX_STALL);

    logic [RUN_W-1:0] stall_run_r;
    logic [RUN_W-1:0] stall_run_nxt_s;
    logic             stall_err_r;
    logic             stall_err_nxt_s;

    // Next run length and error: error latches on the edge the run hits MAX_STALL+1
    always_comb begin
        stall_run_nxt_s = stall_run_r;
        stall_err_nxt_s = stall_err_r;
        if (stall) begin
            if (stall_run_r == RUN_MAX) begin
                stall_run_nxt_s = stall_run_r;
            end else begin
                stall_run_nxt_s = stall_run_r + {{(RUN_W-1){1'b0}}, 1'b1};
            end
            if (stall_run_r >= RUN_LIM) begin
                stall_err_nxt_s = 1'b1;
            end else begin
                stall_err_nxt_s = stall_err_r;
            end
        end else begin
            stall_run_nxt_s = {RUN_W{1'b0}};
            stall_err_nxt_s = stall_err_r;
        end
    end

    // Watchdog state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_run_r <= {RUN_W{1'b0}};
            stall_err_r <= 1'b0;
        end else begin
            stall_run_r <= stall_run_nxt_s;
            stall_err_r <= stall_err_nxt_s;
        end
    end

    assign stall_err = stall_err_r;

endmodule

// File: rtl/stall_ctl.sv
// PC and IF/ID register owner: freezes fetch/decode on stall, injects ID/EX bubbles,
// applies ID-stage redirects. Define STALL_CNT_EN to build the total stall counter.
module stall_ctl
    import stall_ctl_pkg::*;
#(
    parameter int                  PC_WIDTH  = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = PC_WIDTH'(RESET_PC_DEF),
    parameter int                  MAX_STALL = MAX_STALL_DEF,
    parameter logic [31:0]         NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic                clk_87,
    input  logic                rst_87,
    input  logic                stall_87,
    input  logic                branch_taken_87,
    input  logic [PC_WIDTH-1:0] branch_tgt_87,
    input  logic [31:0]         imem_data_87,
    output logic [PC_WIDTH-1:0] imem_addr_87,
    output logic [31:0]         ifid_instr_87,
    output logic [PC_WIDTH-1:0] ifid_pc4_87,
    output logic                ifid_valid_87,
    output logic                idex_valid_87,
    output logic                stall_err_87,
    output logic [31:0]         stall_cnt_87
);

    logic [PC_WIDTH-1:0] pc_r;
    logic [PC_WIDTH-1:0] pc_nxt_s;
    logic [PC_WIDTH-1:0] pc_plus4_s;
    logic [31:0]         ifid_instr_r;
    logic [31:0]         ifid_instr_nxt_s;
    logic [PC_WIDTH-1:0] ifid_pc4_r;
    logic [PC_WIDTH-1:0] ifid_pc4_nxt_s;
    logic                ifid_valid_r;
    logic                ifid_valid_nxt_s;
    logic                idex_valid_r;
    logic                idex_valid_nxt_s;

    assign pc_plus4_s = pc_r + PC_WIDTH'(32'd4);

    // Next-state selection: stall beats branch beats sequential fetch
    always_comb begin
        pc_nxt_s         = pc_r;
        ifid_instr_nxt_s = ifid_instr_r;
        ifid_pc4_nxt_s   = ifid_pc4_r;
        ifid_valid_nxt_s = ifid_valid_r;
        idex_valid_nxt_s = 1'b0;
        if (stall_87) begin
            // branch is dropped here; it re-resolves in ID once the stall clears
            idex_valid_nxt_s = 1'b0;
        end else if (branch_taken_87) begin
            pc_nxt_s         = branch_tgt_87;
            ifid_instr_nxt_s = NOP_INSTR;
            ifid_valid_nxt_s = 1'b0;
            idex_valid_nxt_s = ifid_valid_r;
        end else begin
            pc_nxt_s         = pc_plus4_s;
            ifid_instr_nxt_s = imem_data_87;
            ifid_pc4_nxt_s   = pc_plus4_s;
            ifid_valid_nxt_s = 1'b1;
            idex_valid_nxt_s = ifid_valid_r;
        end
    end

    // PC, IF/ID and ID/EX valid registers
    always_ff @(posedge clk_87 or negedge rst_87) begin
        if (!rst_87) begin
            pc_r         <= RESET_PC;
            ifid_instr_r <= NOP_INSTR;
            ifid_pc4_r   <= {PC_WIDTH{1'b0}};
            ifid_valid_r <= 1'b0;
            idex_valid_r <= 1'b0;
        end else begin
            pc_r         <= pc_nxt_s;
            ifid_instr_r <= ifid_instr_nxt_s;
            ifid_pc4_r   <= ifid_pc4_nxt_s;
            ifid_valid_r <= ifid_valid_nxt_s;
            idex_valid_r <= idex_valid_nxt_s;
        end
    end

    stall_watchdog #(
        .MAX_STALL (MAX_STALL)
    ) u_watchdog (
        .clk       (clk_87),
        .rst_n     (rst_87),
        .stall     (stall_87),
        .stall_err (stall_err_87)
    );

`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt_r;

    // Free-running total of stall cycles, wraps at 2^32
    always_ff @(posedge clk_87 or negedge rst_87) begin
        if (!rst_87) begin
            stall_cnt_r <= 32'd0;
        end else if (stall_87) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt_87 = stall_cnt_r;
`else
    assign stall_cnt_87 = 32'd0;
`endif

    assign imem_addr_87  = pc_r;
    assign ifid_instr_87 = ifid_instr_r;
    assign ifid_pc4_87   = ifid_pc4_r;
    assign ifid_valid_87 = ifid_valid_r;
    assign idex_valid_87 = idex_valid_r;

endmodule
